// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB3 register-file completer.
// Contents: phase enum, default geometry, address error decode.
// Optional feature macro used by the top: APB_SLV_WAIT_EN (access-phase wait states).
package apb_slv_pkg;

    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned IDX_W     = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Misaligned or beyond the last word; out-of-range addresses never wrap.
    function automatic logic decode_err(input logic [31:0] addr,
                                        input int unsigned depth = DEPTH_DEF);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/apb_slv_regs.sv
// DEPTH x DATA_WIDTH register array, cleared asynchronously.
// Ports:
//   clk, rst_n            clock, async active-low clear
//   we_i, wr_idx_i,       single synchronous write port
//   wdata_i
//   rd_idx_i, rdata_o     combinational read port
module apb_slv_regs #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = apb_slv_pkg::DEPTH_DEF,
    parameter int unsigned IDX_W      = apb_slv_pkg::IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage with async clear and one write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer fronting a DEPTH-word register file.
// Ports:
//   PCLK, PRESET          bus clock, async active-low reset
//   PSELx, PENABLE,       APB request (select, access phase, direction)
//   PWRITE
//   PADDR, PWDATA         byte address and write data (captured in setup)
//   PRDATA, PREADY,       registered response
//   PSLVERR
// Optional feature: define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states
// in every access phase; without it every transfer completes with zero waits.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned REG_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("apb_slave_regfile: WAIT_CYCLES must be in 0..15");
    end

    state_e                state_q, state_d, phase_c;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [REG_IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  setup_err_c;
    logic [REG_IDX_W-1:0]  setup_idx_c;
    logic [REG_IDX_W-1:0]  rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  we_c;
    logic                  resp_c;
    logic                  resp_write_c;
    logic                  resp_err_c;

`ifdef APB_SLV_WAIT_EN
    localparam int unsigned CNT_W = 4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign setup_err_c = decode_err(32'(PADDR), DEPTH);
    assign setup_idx_c = REG_IDX_W'(PADDR >> 2);

    // The setup cycle lasts exactly one bus cycle, so it is decoded from IDLE
    // plus the bus request rather than held in the state register; the
    // completing access always returns to IDLE, which lets a back-to-back
    // setup be recognised in the very next cycle.
    always_comb begin
        phase_c = state_q;
        if ((state_q == IDLE) && PSELx && !PENABLE) begin
            phase_c = SETUP;
        end
    end

    // Next-state, capture, commit and response logic.
    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        slverr_d     = 1'b0;
        rdata_d      = rdata_q;
        write_d      = write_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        we_c         = 1'b0;
        rd_idx_c     = idx_q;
        resp_c       = 1'b0;
        resp_write_c = write_q;
        resp_err_c   = err_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d        = cnt_q;
`endif
        unique case (phase_c)
            SETUP: begin
                state_d      = ACCESS;
                write_d      = PWRITE;
                err_d        = setup_err_c;
                idx_d        = setup_idx_c;
                wdata_d      = PWDATA;
                rd_idx_c     = setup_idx_c;
                resp_write_c = PWRITE;
                resp_err_c   = setup_err_c;
`ifdef APB_SLV_WAIT_EN
                cnt_d        = CNT_W'(WAIT_CYCLES);
                resp_c       = (WAIT_CYCLES == 0);
`else
                resp_c       = 1'b1;
`endif
            end
            ACCESS: begin
                state_d = IDLE;
                if (ready_q) begin
                    // Completion edge: errored writes never reach the array.
                    we_c = PSELx && PENABLE && write_q && !err_q;
`ifdef APB_SLV_WAIT_EN
                end else if (PSELx && PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = cnt_q - CNT_W'(1);
                    resp_c  = (cnt_d == '0);
                end else begin
                    // Requester abandoned the transfer during wait states.
                    cnt_d = '0;
`endif
                end
            end
            default: ;
        endcase

        if (resp_c) begin
            ready_d  = 1'b1;
            slverr_d = resp_err_c;
            if (!resp_write_c) begin
                rdata_d = resp_err_c ? '0 : rd_data_c;
            end
        end
    end

    // State and response registers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef APB_SLV_WAIT_EN
    // Wait-state counter.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    apb_slv_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (REG_IDX_W)
    ) u_regs (
        .clk      (PCLK),
        .rst_n    (PRESET),
        .we_i     (we_c),
        .wr_idx_i (idx_q),
        .wdata_i  (wdata_q),
        .rd_idx_i (rd_idx_c),
        .rdata_o  (rd_data_c)
    );

    assign PRDATA  = rdata_q;
    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed APB transfers plus
// randomized traffic against a word-array model of the register file.
module tb_apb_slave_regfile;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAITC = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int unsigned W = WAITC;
`else
    localparam int unsigned W = 0;
`endif

    logic          PCLK    = 1'b0;
    logic          PRESET  = 1'b0;
    logic          PSELx   = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE  = 1'b0;
    logic [AW-1:0] PADDR   = '0;
    logic [DW-1:0] PWDATA  = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_slave_regfile #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSELx   (PSELx),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Reference model: register contents, last read data, expected outputs.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rdata = '0;
    logic          exp_ready  = 1'b0;
    logic          exp_err    = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;
    bit            chk_en     = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge PCLK) begin
        if (chk_en) begin
            check("cyc_PREADY",  32'(PREADY),  32'(exp_ready));
            check("cyc_PSLVERR", 32'(PSLVERR), 32'(exp_err));
            check("cyc_PRDATA",  PRDATA,       exp_rdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_err(input logic [AW-1:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        last_rdata = '0;
    endtask

    // One APB transfer; the access phase lasts W+1 cycles per the model.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit idle_after, output logic [DW-1:0] got_rdata,
                        output logic got_err, output int low_cycles);
        bit e;
        e = model_err(addr);
        low_cycles = 0;
        got_rdata  = '0;
        got_err    = 1'b0;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = last_rdata;
        tick();
        PENABLE = 1'b1;
        // Access-phase changes must be ignored.
        PADDR  = AW'($urandom);
        PWDATA = $urandom;
        PWRITE = 1'($urandom);
        for (int k = 0; k <= int'(W); k++) begin
            if (k == int'(W)) begin
                exp_ready = 1'b1;
                exp_err   = e;
                if (!wr) last_rdata = e ? '0 : ref_mem[addr / 4];
            end else begin
                exp_ready = 1'b0;
                exp_err   = 1'b0;
            end
            exp_rdata = last_rdata;
            if (PREADY === 1'b0) low_cycles++;
            if (k == int'(W)) begin
                got_rdata = PRDATA;
                got_err   = PSLVERR;
            end
            tick();
        end
        if (wr && !e) ref_mem[addr / 4] = data;
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = last_rdata;
        if (idle_after) begin
            PSELx = 1'b0; PENABLE = 1'b0;
            tick();
        end
    endtask

    // Reset asserted during the first access cycle of a write.
    task automatic reset_mid();
        chk_en = 1'b0;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h5A5A5A5A;
        tick();
        PENABLE = 1'b1;
        #2;
        PRESET = 1'b0;
        #1;
        check("rst_mid_PREADY",  32'(PREADY),  32'h0);
        check("rst_mid_PSLVERR", 32'(PSLVERR), 32'h0);
        check("rst_mid_PRDATA",  PRDATA,       32'h0);
        PSELx = 1'b0; PENABLE = 1'b0;
        model_clear();
        tick();
        PRESET = 1'b1;
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        chk_en = 1'b1;
        tick();
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            lc;
        logic [AW-1:0] a;
        bit            wr;

        model_clear();
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        check("reset_PREADY",  32'(PREADY),  32'h0);
        check("reset_PSLVERR", 32'(PSLVERR), 32'h0);
        check("reset_PRDATA",  PRDATA,       32'h0);
        chk_en = 1'b1;
        tick();

        xfer(1'b0, 8'h04, '0, 1'b1, rd, er, lc);
        check("rd04_after_reset", rd, 32'h0);

        xfer(1'b1, 8'h08, 32'hDEADBEEF, 1'b1, rd, er, lc);
        xfer(1'b0, 8'h08, '0, 1'b1, rd, er, lc);
        check("rd08_data", rd, 32'hDEADBEEF);
        check("rd08_err",  32'(er), 32'h0);
        check("rd08_wait_cycles", 32'(lc), 32'(W));

        xfer(1'b1, 8'h04, 32'h11111111, 1'b1, rd, er, lc);
        xfer(1'b1, 8'h06, 32'hCAFEF00D, 1'b1, rd, er, lc);
        check("misaligned_wr_err", 32'(er), 32'h1);
        xfer(1'b0, 8'h04, '0, 1'b1, rd, er, lc);
        check("reg1_unchanged", rd, 32'h11111111);

        xfer(1'b0, 8'h40, '0, 1'b1, rd, er, lc);
        check("oor_rd_err",  32'(er), 32'h1);
        check("oor_rd_data", rd, 32'h0);

        xfer(1'b1, 8'h0C, 32'h00001234, 1'b0, rd, er, lc);
        xfer(1'b0, 8'h0C, '0, 1'b1, rd, er, lc);
        check("b2b_rd0C", rd, 32'h00001234);

        xfer(1'b1, 8'h00, 32'hA5A5A5A5, 1'b1, rd, er, lc);
        check("wr00_wait_cycles", 32'(lc), 32'(W));
        check("wr00_err", 32'(er), 32'h0);
        xfer(1'b0, 8'h00, '0, 1'b1, rd, er, lc);
        check("rd00_data", rd, 32'hA5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) == 0) a = AW'($urandom);
            else a = AW'($urandom_range(0, DEPTH - 1) * 4);
            xfer(wr, a, $urandom, (i == 299) ? 1'b1 : 1'($urandom), rd, er, lc);
        end

        reset_mid();
        xfer(1'b0, 8'h00, '0, 1'b1, rd, er, lc);
        check("rd00_after_reset", rd, 32'h0);
        xfer(1'b0, 8'h08, '0, 1'b1, rd, er, lc);
        check("rd08_after_reset", rd, 32'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
